// File: rtl/cfg_pkg.sv
// Shared constants and helpers for the cfg bus arbiter slice.
package cfg_pkg;

  localparam int AXI_WIDTH_DEF  = 32;
  localparam int CFG_AWIDTH_DEF = 5;
  localparam int RSP_LATENCY    = 2;

  // Index width for a requester count; a single bit is kept even for tiny counts.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/cfg_bus_arbiter_if.sv
// Requester-side handshake bundle of the cfg bus arbiter.
// CFG_ARB_LOCK_EN adds the per-master req_lock input.
interface cfg_bus_arbiter_if
  import cfg_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AXI_WIDTH   = AXI_WIDTH_DEF,
  parameter int CFG_AWIDTH  = CFG_AWIDTH_DEF
) ();

  logic [NUM_MASTERS-1:0]            req_valid;
  logic [NUM_MASTERS-1:0]            req_wr;
  logic [NUM_MASTERS*CFG_AWIDTH-1:0] req_addr;
  logic [NUM_MASTERS*AXI_WIDTH-1:0]  req_wdata;
  logic [NUM_MASTERS-1:0]            req_ready;
  logic [NUM_MASTERS-1:0]            rsp_valid;
  logic [AXI_WIDTH-1:0]              rsp_rdata;
`ifdef CFG_ARB_LOCK_EN
  logic [NUM_MASTERS-1:0]            req_lock;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_lock,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_lock,
    output req_ready, rsp_valid, rsp_rdata
  );
`else
  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif

endinterface

// File: rtl/cfg_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping.
module cfg_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDXW        = 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDXW-1:0]        ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDXW-1:0]        idx_o
);

  logic          found_s;
  logic [IDXW:0] pos_s;

  // Scan upward from the pointer; the extra pos_s bit absorbs the wrap.
  always_comb begin
    gnt_o   = {NUM_MASTERS{1'b0}};
    idx_o   = {IDXW{1'b0}};
    found_s = 1'b0;
    pos_s   = {(IDXW+1){1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      pos_s = {1'b0, ptr_i} + (IDXW+1)'(i);
      pos_s = (pos_s >= (IDXW+1)'(NUM_MASTERS)) ? pos_s - (IDXW+1)'(NUM_MASTERS) : pos_s;
      if (!found_s && req_i[pos_s[IDXW-1:0]]) begin
        found_s                    = 1'b1;
        gnt_o[pos_s[IDXW-1:0]]     = 1'b1;
        idx_o                      = pos_s[IDXW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Shares one cfg register port between NUM_MASTERS requesters, round-robin, with
// a fixed two-cycle response pipe. CFG_ARB_LOCK_EN enables req_lock holding.
module cfg_bus_arbiter
  import cfg_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AXI_WIDTH   = AXI_WIDTH_DEF,
  parameter int CFG_AWIDTH  = CFG_AWIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  cfg_bus_arbiter_if.slave      bus,
  output logic                  cfg_wr_en,
  output logic [CFG_AWIDTH-1:0] cfg_wr_addr,
  output logic [AXI_WIDTH-1:0]  cfg_wr_data,
  output logic                  cfg_rd_en,
  output logic [CFG_AWIDTH-1:0] cfg_rd_addr,
  input  logic [AXI_WIDTH-1:0]  cfg_rd_data
);

  localparam int              IDXW     = idx_width(NUM_MASTERS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_MASTERS - 1);
  localparam int              LAT      = RSP_LATENCY;

  logic [IDXW-1:0]        ptr_q, ptr_d;
  logic [IDXW-1:0]        arb_ptr_s, win_idx_s;
  logic [NUM_MASTERS-1:0] arb_req_s, gnt_s;
  logic                   hs_s, win_wr_s, rsp_rd_s;
  logic [CFG_AWIDTH-1:0]  win_addr_s;
  logic [AXI_WIDTH-1:0]   win_wdata_s;
  logic [LAT-1:0]         pv_q, prd_q;
  logic [IDXW-1:0]        pidx_q [LAT];
  logic [AXI_WIDTH-1:0]   rdata_q;
`ifdef CFG_ARB_LOCK_EN
  logic [IDXW-1:0]        own_q, own_d;
  logic                   own_vld_q, own_vld_d;
  logic                   locked_s;
`endif

  // While the last winner holds its lock, the search is pinned to it alone.
  always_comb begin
`ifdef CFG_ARB_LOCK_EN
    locked_s = own_vld_q & bus.req_lock[own_q];
    if (locked_s) begin
      arb_ptr_s = own_q;
      arb_req_s = bus.req_valid & ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << own_q);
    end else begin
      arb_ptr_s = ptr_q;
      arb_req_s = bus.req_valid;
    end
`else
    arb_ptr_s = ptr_q;
    arb_req_s = bus.req_valid;
`endif
  end

  cfg_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDXW        (IDXW)
  ) u_rr (
    .req_i (arb_req_s),
    .ptr_i (arb_ptr_s),
    .gnt_o (gnt_s),
    .idx_o (win_idx_s)
  );

  assign bus.req_ready = rst ? {NUM_MASTERS{1'b0}} : gnt_s;
  assign hs_s          = ~rst & (|gnt_s);
  assign win_wr_s      = bus.req_wr[win_idx_s];
  assign win_addr_s    = bus.req_addr[win_idx_s*CFG_AWIDTH +: CFG_AWIDTH];
  assign win_wdata_s   = bus.req_wdata[win_idx_s*AXI_WIDTH +: AXI_WIDTH];

  // Pointer and lock-owner next state.
  always_comb begin
    ptr_d = ptr_q;
`ifdef CFG_ARB_LOCK_EN
    own_d     = own_q;
    own_vld_d = own_vld_q;
`endif
    if (hs_s) begin
      if (win_idx_s == LAST_IDX) begin
        ptr_d = {IDXW{1'b0}};
      end else begin
        ptr_d = win_idx_s + IDXW'(1);
      end
`ifdef CFG_ARB_LOCK_EN
      own_d     = win_idx_s;
      own_vld_d = bus.req_lock[win_idx_s];
    end else if (!locked_s) begin
      own_vld_d = 1'b0;
`endif
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Issue stage, response pipe and read-data hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= {IDXW{1'b0}};
      cfg_wr_en   <= 1'b0;
      cfg_rd_en   <= 1'b0;
      cfg_wr_addr <= {CFG_AWIDTH{1'b0}};
      cfg_rd_addr <= {CFG_AWIDTH{1'b0}};
      cfg_wr_data <= {AXI_WIDTH{1'b0}};
      pv_q        <= {LAT{1'b0}};
      prd_q       <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        pidx_q[i] <= {IDXW{1'b0}};
      end
      rdata_q     <= {AXI_WIDTH{1'b0}};
`ifdef CFG_ARB_LOCK_EN
      own_q       <= {IDXW{1'b0}};
      own_vld_q   <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      cfg_wr_en   <= hs_s & win_wr_s;
      cfg_rd_en   <= hs_s & ~win_wr_s;
      cfg_wr_addr <= (hs_s & win_wr_s)  ? win_addr_s  : {CFG_AWIDTH{1'b0}};
      cfg_rd_addr <= (hs_s & ~win_wr_s) ? win_addr_s  : {CFG_AWIDTH{1'b0}};
      cfg_wr_data <= (hs_s & win_wr_s)  ? win_wdata_s : {AXI_WIDTH{1'b0}};
      pv_q[0]     <= hs_s;
      prd_q[0]    <= ~win_wr_s;
      pidx_q[0]   <= win_idx_s;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i]   <= pv_q[i-1];
        prd_q[i]  <= prd_q[i-1];
        pidx_q[i] <= pidx_q[i-1];
      end
      if (rsp_rd_s) begin
        rdata_q <= cfg_rd_data;
      end else begin
        rdata_q <= rdata_q;
      end
`ifdef CFG_ARB_LOCK_EN
      own_q       <= own_d;
      own_vld_q   <= own_vld_d;
`endif
    end
  end

  assign rsp_rd_s = pv_q[LAT-1] & prd_q[LAT-1];

  // Response: read data comes straight from the register file in the response cycle.
  always_comb begin
    bus.rsp_valid = {NUM_MASTERS{1'b0}};
    if (~rst & pv_q[LAT-1]) begin
      bus.rsp_valid[pidx_q[LAT-1]] = 1'b1;
    end else begin
      bus.rsp_valid = {NUM_MASTERS{1'b0}};
    end
    if (rsp_rd_s) begin
      bus.rsp_rdata = cfg_rd_data;
    end else begin
      bus.rsp_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Directed scoreboard bench for cfg_bus_arbiter with a small register-file model.
module tb_cfg_bus_arbiter;
  import cfg_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int CA = 5;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } iss_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] data;
  } rsp_t;

  logic          clk;
  logic          rst;
  logic          env_clr;
  logic          cfg_wr_en, cfg_rd_en;
  logic [CA-1:0] cfg_wr_addr, cfg_rd_addr;
  logic [AW-1:0] cfg_wr_data, cfg_rd_data;

  cfg_bus_arbiter_if #(.NUM_MASTERS(N), .AXI_WIDTH(AW), .CFG_AWIDTH(CA)) bus ();

  cfg_bus_arbiter #(.NUM_MASTERS(N), .AXI_WIDTH(AW), .CFG_AWIDTH(CA)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .cfg_rd_en   (cfg_rd_en),
    .cfg_rd_addr (cfg_rd_addr),
    .cfg_rd_data (cfg_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [4:0] a);
    return 32'h1234_5671 + {27'd0, a};
  endfunction

  // Register file: unwritten words read as init_val; data returned the cycle after rd_en.
  logic [31:0] mem [32];
  logic [31:0] wr_mask;
  always_ff @(posedge clk) begin
    if (env_clr) begin
      wr_mask <= 32'd0;
    end else if (cfg_wr_en) begin
      mem[cfg_wr_addr]     <= cfg_wr_data;
      wr_mask[cfg_wr_addr] <= 1'b1;
    end
    if (cfg_rd_en) begin
      cfg_rd_data <= wr_mask[cfg_rd_addr] ? mem[cfg_rd_addr] : init_val(cfg_rd_addr);
    end
  end

  int cyc;
  always_ff @(posedge clk) begin
    if (env_clr) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int          checks;
  int          errors;
  iss_t        issq[$];
  rsp_t        rspq[$];
  logic [31:0] shadow [32];
  logic [31:0] last_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One request cycle: drive, check the grant, queue the expected issue and response.
  task automatic step(input logic [1:0] v, input logic [1:0] w,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] eg, input string nm);
    int          idx;
    logic [4:0]  a;
    logic [31:0] d;
    bus.req_valid = v;
    bus.req_wr    = w;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    @(negedge clk);
    chk({nm, " gnt"}, 64'(bus.req_ready), 64'(eg));
    if (eg != 2'b00) begin
      idx = eg[1] ? 1 : 0;
      a   = eg[1] ? a1 : a0;
      d   = eg[1] ? d1 : d0;
      issq.push_back('{cyc: cyc + 1, wr: w[idx], addr: a, data: d});
      if (w[idx]) begin
        rspq.push_back('{cyc: cyc + 2, idx: idx, data: last_rd});
        shadow[a] = d;
      end else begin
        last_rd = shadow[a];
        rspq.push_back('{cyc: cyc + 2, idx: idx, data: last_rd});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00, "idle");
    end
  endtask

  initial begin
    iss_t        ie;
    rsp_t        re;
    logic [1:0]  oh;
    checks        = 0;
    errors        = 0;
    last_rd       = 32'd0;
    rst           = 1'b1;
    env_clr       = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_wr    = 2'b00;
    bus.req_addr  = 10'd0;
    bus.req_wdata = 64'd0;
`ifdef CFG_ARB_LOCK_EN
    bus.req_lock  = 2'b00;
`endif
    for (int i = 0; i < 32; i++) shadow[i] = init_val(5'(i));

    // Monitor: pops an expectation whenever the DUT strobes or responds.
    fork
      begin
        @(posedge clk);
        forever begin
          @(negedge clk);
          chk("strobe exclusive", 64'(cfg_wr_en & cfg_rd_en), 64'd0);
          if (cfg_wr_en | cfg_rd_en) begin
            if (issq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected strobe actual wr=%0b rd=%0b expected none", cfg_wr_en, cfg_rd_en);
            end else begin
              ie = issq.pop_front();
              chk("iss cycle", 64'(cyc), 64'(ie.cyc));
              chk("iss wr_en", 64'(cfg_wr_en), 64'(ie.wr));
              chk("iss rd_en", 64'(cfg_rd_en), 64'(!ie.wr));
              if (ie.wr) begin
                chk("iss wr_addr", 64'(cfg_wr_addr), 64'(ie.addr));
                chk("iss wr_data", 64'(cfg_wr_data), 64'(ie.data));
                chk("iss rd_addr idle", 64'(cfg_rd_addr), 64'd0);
              end else begin
                chk("iss rd_addr", 64'(cfg_rd_addr), 64'(ie.addr));
                chk("iss wr_addr idle", 64'(cfg_wr_addr), 64'd0);
              end
            end
          end
          if (bus.rsp_valid != 2'b00) begin
            if (rspq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected rsp actual rsp_valid=%0b expected none", bus.rsp_valid);
            end else begin
              re = rspq.pop_front();
              oh = (re.idx == 1) ? 2'b10 : 2'b01;
              chk("rsp cycle", 64'(cyc), 64'(re.cyc));
              chk("rsp valid", 64'(bus.rsp_valid), 64'(oh));
              chk("rsp rdata", 64'(bus.rsp_rdata), 64'(re.data));
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(bus.req_ready), 64'd0);
    chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset strobes", 64'({cfg_wr_en, cfg_rd_en}), 64'd0);
    chk("reset addrs", 64'({cfg_wr_addr, cfg_rd_addr}), 64'd0);
    chk("reset rdata", 64'(bus.rsp_rdata), 64'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    env_clr = 1'b0;
    idle(1);

    step(2'b01, 2'b01, 5'd3, 5'd0, 32'hDEAD_BEEF, 32'd0, 2'b01, "m0 write");
    idle(3);
    step(2'b10, 2'b00, 5'd0, 5'd7, 32'd0, 32'd0, 2'b10, "m1 read");
    idle(3);

    rst     = 1'b1;
    last_rd = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b00, 5'd3, 5'd9, 32'd0, 32'd0, (k % 2 == 0) ? 2'b01 : 2'b10, "alt read");
    end
    idle(3);

    step(2'b01, 2'b01, 5'd4, 5'd0, 32'hCAFE_F00D, 32'd0, 2'b01, "b2b write");
    step(2'b01, 2'b00, 5'd4, 5'd0, 32'd0, 32'd0, 2'b01, "b2b read");
    idle(3);

    step(2'b01, 2'b00, 5'd12, 5'd0, 32'd0, 32'd0, 2'b01, "pre-rst read");
    rst           = 1'b1;
    bus.req_valid = 2'b11;
    rspq.delete();
    last_rd       = 32'd0;
    @(negedge clk);
    chk("rst ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("post-rst strobes", 64'({cfg_wr_en, cfg_rd_en}), 64'd0);
    chk("post-rst rd_addr", 64'(cfg_rd_addr), 64'd0);
    chk("post-rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    step(2'b11, 2'b00, 5'd5, 5'd6, 32'd0, 32'd0, 2'b01, "post-rst grant");
    idle(3);

`ifdef CFG_ARB_LOCK_EN
    bus.req_lock = 2'b10;
    step(2'b11, 2'b00, 5'd8, 5'd10, 32'd0, 32'd0, 2'b10, "lock read");
    step(2'b11, 2'b10, 5'd8, 5'd10, 32'd0, 32'h0BAD_F00D, 2'b10, "lock write");
    step(2'b01, 2'b00, 5'd8, 5'd10, 32'd0, 32'd0, 2'b00, "lock hold");
    bus.req_lock = 2'b00;
    step(2'b01, 2'b00, 5'd8, 5'd10, 32'd0, 32'd0, 2'b01, "lock release");
    idle(3);
`endif

    chk("issue queue drained", 64'(issq.size()), 64'd0);
    chk("rsp queue drained", 64'(rspq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
